// File: rtl/arc_debug_pkg.sv
// Shared constants for the debug dumper: ASCII framing bytes, line length
// and the controller state encoding.
package arc_debug_pkg;

    localparam logic [7:0] COLON   = 8'h3A;
    localparam logic [7:0] NEWLINE = 8'h0A;

    localparam int         LINE_BYTES = 12;
    localparam logic [3:0] LAST_CHAR  = 4'(LINE_BYTES - 1);

    // Character slots inside one line
    localparam logic [3:0] CHAR_ADDR_HI = 4'd0;
    localparam logic [3:0] CHAR_ADDR_LO = 4'd1;
    localparam logic [3:0] CHAR_COLON   = 4'd2;
    localparam logic [3:0] CHAR_WORD_HI = 4'd3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_NEXT    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/arc_hex_ascii.sv
// Nibble to uppercase ASCII hex digit.
module arc_hex_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/arc_debug_dumper.sv
// Sweeps the CPU debug read port and streams each word as an ASCII hex line
// ("AA:DDDDDDDD\n") over a valid/ready byte interface, holding the CPU halted.
//
// state   | meaning
// IDLE    | waiting for trigger, CPU free-running
// SETTLE  | debug_addr held stable while the debug port settles
// CAPTURE | debug_data registered into the capture word
// SEND    | streaming the 12 characters of the current line
// NEXT    | advance address or finish the sweep
// DONE    | one-cycle done pulse, then back to IDLE
module arc_debug_dumper
    import arc_debug_pkg::*;
#(
    parameter int                ADDR_W     = 7,
    parameter logic [ADDR_W-1:0] ADDR_FIRST = 'h00,
    parameter logic [ADDR_W-1:0] ADDR_LAST  = 'h43,
    parameter int                SETTLE     = 2
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              trigger,
    output logic [ADDR_W-1:0] debug_addr,
    input  logic [31:0]       debug_data,
    output logic              halt_req,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] SETTLE_TC = 4'(SETTLE - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        settle_q, settle_d;
    logic [3:0]        idx_q, idx_d;
    logic [31:0]       cap_q, cap_d;

    logic [7:0] addr8;
    logic [2:0] word_nib;
    logic [3:0] nibble;
    logic [7:0] hex_char;
    logic [7:0] line_char;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        settle_d = settle_q;
        idx_d    = idx_q;
        cap_d    = cap_q;

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    addr_d   = ADDR_FIRST;
                    settle_d = 4'd0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_TC) begin
                    state_d = ST_CAPTURE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_CAPTURE: begin
                cap_d   = debug_data;
                idx_d   = 4'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_CHAR) begin
                        state_d = ST_NEXT;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_NEXT: begin
                // Compare before incrementing so the sweep never wraps past ADDR_LAST
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d   = addr_q + 1'b1;
                    settle_d = 4'd0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            addr_q   <= ADDR_FIRST;
            settle_q <= 4'd0;
            idx_q    <= 4'd0;
            cap_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            cap_q    <= cap_d;
        end
    end

    assign addr8    = 8'(addr_q);
    // Char 3 carries the top nibble of the word, char 10 the bottom one
    assign word_nib = 3'(4'd10 - idx_q);

    always_comb begin
        case (idx_q)
            CHAR_ADDR_HI: nibble = addr8[7:4];
            CHAR_ADDR_LO: nibble = addr8[3:0];
            default:      nibble = cap_q[{word_nib, 2'b00} +: 4];
        endcase
    end

    arc_hex_ascii u_hex (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    always_comb begin
        if (idx_q == CHAR_COLON) begin
            line_char = COLON;
        end else if (idx_q == LAST_CHAR) begin
            line_char = NEWLINE;
        end else begin
            line_char = hex_char;
        end
    end

    assign tx_valid   = (state_q == ST_SEND);
    assign tx_data    = tx_valid ? line_char : 8'h00;
    assign debug_addr = addr_q;
    assign busy       = (state_q != ST_IDLE);
    assign halt_req   = busy;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_arc_debug_dumper.sv
// Bench for arc_debug_dumper: a full-range instance and a single-address
// instance, checked against a queue of expected ASCII line bytes.
module tb_arc_debug_dumper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn = 1'b0;
    logic        trig_m = 1'b0, trig_o = 1'b0;
    logic        rdy_fix = 1'b1, rand_mode = 1'b0, rnd_rdy = 1'b1;
    logic        rdy_m, rdy_o;
    logic [6:0]  addr_m, addr_o;
    logic [31:0] data_m, data_o = 32'd0;
    logic        halt_m, halt_o, val_m, val_o, busy_m, busy_o, done_m, done_o;
    logic [7:0]  txd_m, txd_o;

    assign data_m = {25'b0, addr_m};
    assign rdy_m  = rand_mode ? rnd_rdy : rdy_fix;
    assign rdy_o  = 1'b1;

    arc_debug_dumper u_main (
        .clk(clk), .aresetn(aresetn), .trigger(trig_m), .debug_addr(addr_m),
        .debug_data(data_m), .halt_req(halt_m), .tx_data(txd_m), .tx_valid(val_m),
        .tx_ready(rdy_m), .busy(busy_m), .done(done_m)
    );

    arc_debug_dumper #(.ADDR_FIRST(7'h05), .ADDR_LAST(7'h05)) u_one (
        .clk(clk), .aresetn(aresetn), .trigger(trig_o), .debug_addr(addr_o),
        .debug_data(data_o), .halt_req(halt_o), .tx_data(txd_o), .tx_valid(val_o),
        .tx_ready(rdy_o), .busy(busy_o), .done(done_o)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] q_m[$];
    logic [7:0] q_o[$];
    logic [7:0] log_o[$];
    logic [7:0] last_m[$];
    int hs_m = 0, dn_m = 0, dn_o = 0;
    logic stall_m = 0, stall_o = 0, pv_m = 0, dp_m = 0, dp_o = 0;
    logic [7:0] pd_m, pd_o;
    logic [6:0] pa_m;
    string hexs = "0123456789ABCDEF";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected line from the text format: two address digits, colon, eight word digits, newline
    task automatic push_line(input int which, input logic [6:0] a, input logic [31:0] d);
        logic [7:0] ln[$];
        int av;
        av = int'(a);
        ln.push_back(hexs[av / 16]);
        ln.push_back(hexs[av % 16]);
        ln.push_back(8'h3A);
        for (int k = 7; k >= 0; k--) ln.push_back(hexs[int'((d >> (4 * k)) & 32'hF)]);
        ln.push_back(8'h0A);
        foreach (ln[i]) begin
            if (which == 0) q_m.push_back(ln[i]);
            else q_o.push_back(ln[i]);
        end
    endtask

    task automatic push_range();
        for (int a = 0; a <= 'h43; a++) push_line(0, 7'(a), 32'(a));
    endtask

    task automatic wait_done(input int which, input int budget);
        int start;
        start = (which == 0) ? dn_m : dn_o;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (((which == 0) ? dn_m : dn_o) > start) return;
        end
        checks++;
        failures++;
        $display("FAIL timeout_done inst=%0d actual=no_done required=done_within_%0d", which, budget);
    endtask

    always @(posedge clk) begin
        #1;
        rnd_rdy = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!aresetn) begin
            q_m.delete();
            q_o.delete();
            stall_m = 0; stall_o = 0; pv_m = 0; dp_m = 0; dp_o = 0;
        end else begin
            check("halt_eq_busy_m", 32'(halt_m), 32'(busy_m));
            check("halt_eq_busy_o", 32'(halt_o), 32'(busy_o));
            check("addr_bound_m", 32'(addr_m <= 7'h43), 32'd1);
            check("addr_fixed_o", 32'(addr_o), 32'h05);
            if (stall_m) begin
                check("hold_valid_m", 32'(val_m), 32'd1);
                check("hold_data_m", 32'(txd_m), 32'(pd_m));
            end
            if (stall_o) check("hold_data_o", 32'(txd_o), 32'(pd_o));
            if (pv_m && val_m) check("addr_stable_send_m", 32'(addr_m), 32'(pa_m));
            if (dp_m) begin
                check("busy_after_done_m", 32'(busy_m), 32'd0);
                check("done_width_m", 32'(done_m), 32'd0);
            end
            if (dp_o) begin
                check("busy_after_done_o", 32'(busy_o), 32'd0);
                check("done_width_o", 32'(done_o), 32'd0);
            end
            if (val_m && rdy_m) begin
                if (q_m.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL byte_m actual=%0h required=no_byte", txd_m);
                end else begin
                    check("byte_m", 32'(txd_m), 32'(q_m.pop_front()));
                end
                hs_m++;
                last_m.push_back(txd_m);
                if (last_m.size() > 12) void'(last_m.pop_front());
            end
            if (val_o && rdy_o) begin
                if (q_o.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL byte_o actual=%0h required=no_byte", txd_o);
                end else begin
                    check("byte_o", 32'(txd_o), 32'(q_o.pop_front()));
                end
                log_o.push_back(txd_o);
            end
            if (done_m) dn_m++;
            if (done_o) dn_o++;
            stall_m = val_m && !rdy_m; pd_m = txd_m;
            stall_o = val_o && !rdy_o; pd_o = txd_o;
            pv_m = val_m; pa_m = addr_m;
            dp_m = done_m; dp_o = done_o;
        end
    end

    logic [7:0] exp_beef[12] = '{8'h30, 8'h35, 8'h3A, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42,
                                  8'h45, 8'h45, 8'h46, 8'h0A};
    logic [7:0] exp_last[12] = '{8'h34, 8'h33, 8'h3A, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
                                  8'h30, 8'h34, 8'h33, 8'h0A};

    initial begin
        int base;
        int hs_base;
        bit hit;

        repeat (3) @(posedge clk);
        #1;
        check("rst_addr_m", 32'(addr_m), 32'h00);
        check("rst_addr_o", 32'(addr_o), 32'h05);
        check("rst_txd_m", 32'(txd_m), 32'h00);
        check("rst_valid_m", 32'(val_m), 32'd0);
        check("rst_busy_m", 32'(busy_m), 32'd0);
        check("rst_halt_m", 32'(halt_m), 32'd0);
        check("rst_done_m", 32'(done_m), 32'd0);
        aresetn = 1'b1;

        // Single address, DEADBEEF
        data_o = 32'hDEADBEEF;
        push_line(1, 7'h05, 32'hDEADBEEF);
        base = log_o.size();
        @(posedge clk); #1;
        trig_o = 1'b1;
        @(posedge clk); #1;
        trig_o = 1'b0;
        check("busy_rise_o", 32'(busy_o), 32'd1);
        wait_done(1, 100);
        repeat (2) @(posedge clk);
        #1;
        check("line_len_o", 32'(log_o.size() - base), 32'd12);
        for (int i = 0; i < 12; i++)
            if (base + i < log_o.size()) check("beef_byte", 32'(log_o[base + i]), 32'(exp_beef[i]));
        check("q_empty_o", 32'(q_o.size()), 32'd0);
        check("busy_idle_o", 32'(busy_o), 32'd0);
        check("done_count_o", 32'(dn_o), 32'd1);

        // Data changes at the edge that loads debug_addr; the later value must be captured
        data_o = 32'h1;
        push_line(1, 7'h05, 32'h2);
        trig_o = 1'b1;
        @(posedge clk); #1;
        trig_o = 1'b0;
        data_o = 32'h2;
        wait_done(1, 100);
        repeat (2) @(posedge clk);
        #1;
        check("q_empty_settle_o", 32'(q_o.size()), 32'd0);

        // Full range, ready always high
        push_range();
        trig_m = 1'b1;
        @(posedge clk); #1;
        trig_m = 1'b0;
        wait_done(0, 3000);
        repeat (2) @(posedge clk);
        #1;
        check("q_empty_m1", 32'(q_m.size()), 32'd0);
        check("done_count_m1", 32'(dn_m), 32'd1);
        check("last_len_m", 32'(last_m.size()), 32'd12);
        for (int i = 0; i < 12; i++)
            if (i < last_m.size()) check("last_line_byte", 32'(last_m[i]), 32'(exp_last[i]));

        // Random ready with a second trigger mid-dump
        push_range();
        rand_mode = 1'b1;
        trig_m = 1'b1;
        @(posedge clk); #1;
        trig_m = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("busy_mid_m", 32'(busy_m), 32'd1);
        trig_m = 1'b1;
        @(posedge clk); #1;
        trig_m = 1'b0;
        wait_done(0, 8000);
        rand_mode = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("done_count_m2", 32'(dn_m), 32'd2);
        check("q_empty_m2", 32'(q_m.size()), 32'd0);
        check("busy_idle_m2", 32'(busy_m), 32'd0);

        // Reset while byte 4 of the first line is on the bus
        push_range();
        hs_base = hs_m;
        trig_m = 1'b1;
        @(posedge clk); #1;
        trig_m = 1'b0;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk); #1;
            if (hs_m - hs_base == 4) hit = 1;
        end
        check("reach_byte4", 32'(hit), 32'd1);
        check("byte4_valid", 32'(val_m), 32'd1);
        check("byte4_data", 32'(txd_m), 32'h30);
        aresetn = 1'b0;
        rdy_fix = 1'b0;
        @(posedge clk); #1;
        check("abort_valid", 32'(val_m), 32'd0);
        check("abort_busy", 32'(busy_m), 32'd0);
        check("abort_halt", 32'(halt_m), 32'd0);
        check("abort_addr", 32'(addr_m), 32'h00);
        check("abort_txd", 32'(txd_m), 32'h00);
        aresetn = 1'b1;
        rdy_fix = 1'b1;
        @(posedge clk); #1;
        push_range();
        trig_m = 1'b1;
        @(posedge clk); #1;
        trig_m = 1'b0;
        wait_done(0, 3000);
        repeat (2) @(posedge clk);
        #1;
        check("q_empty_m3", 32'(q_m.size()), 32'd0);
        check("done_count_m3", 32'(dn_m), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
